// File: rtl/snoop_receptor.sv
// snoop_receptor: bus-side MSI snoop controller for one cache.
// Holds the per-line state/tag table, reacts to bus misses and invalidates
// from other caches, requests write-backs of EXCLUSIVE lines and tells
// memory to abort its response when this cache supplies the data.
module snoop_receptor #(
    parameter int NUM_LINES = 4,
    parameter int TAG_W     = 4,
    parameter int IDX_W     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bus_valid,
    input  logic [2:0]       bus_msg,
    input  logic [IDX_W-1:0] bus_index,
    input  logic [TAG_W-1:0] bus_tag,
    output logic             bus_ready,
    input  logic             loc_we,
    input  logic [IDX_W-1:0] loc_index,
    input  logic [TAG_W-1:0] loc_tag,
    input  logic [1:0]       loc_state,
    input  logic [IDX_W-1:0] rd_index,
    output logic [1:0]       rd_state,
    output logic [TAG_W-1:0] rd_tag,
    output logic             wb_req,
    output logic [IDX_W-1:0] wb_index,
    output logic [TAG_W-1:0] wb_tag,
    input  logic             wb_ack,
    output logic             abort_mem,
    output logic             proto_err
);

    localparam logic [1:0] ST_INV = 2'b00;
    localparam logic [1:0] ST_SHR = 2'b01;
    localparam logic [1:0] ST_EXC = 2'b10;

    localparam logic [2:0] MSG_WM  = 3'b001;
    localparam logic [2:0] MSG_RM  = 3'b010;
    localparam logic [2:0] MSG_INV = 3'b011;

    typedef enum logic {
        IDLE    = 1'b0,
        WB_WAIT = 1'b1
    } fsm_t;

    fsm_t             state_r;
    fsm_t             state_next_s;

    logic [TAG_W-1:0] tag_r [NUM_LINES];
    logic [1:0]       st_r  [NUM_LINES];

    logic             wb_req_r;
    logic [IDX_W-1:0] wb_index_r;
    logic [TAG_W-1:0] wb_tag_r;
    logic             abort_r;
    logic             proto_r;

    logic             msg_ok_s;
    logic             accept_s;
    logic             hit_s;
    logic             upd_s;
    logic [1:0]       new_st_s;
    logic             wb_start_s;
    logic             abort_s;
    logic             proto_s;
    logic [1:0]       loc_st_s;

    // Only the three snoop encodings are meaningful; everything else is dropped.
    assign msg_ok_s  = (bus_msg == MSG_WM) || (bus_msg == MSG_RM) || (bus_msg == MSG_INV);
    assign bus_ready = (state_r == IDLE) && !reset;
    assign accept_s  = bus_valid && bus_ready && msg_ok_s;
    assign hit_s     = (tag_r[bus_index] == bus_tag) && (st_r[bus_index] != ST_INV);
    // The reserved state encoding is never stored; it collapses to INVALID.
    assign loc_st_s  = (loc_state == 2'b11) ? ST_INV : loc_state;

    assign rd_state  = st_r[rd_index];
    assign rd_tag    = tag_r[rd_index];
    assign wb_req    = wb_req_r;
    assign wb_index  = wb_index_r;
    assign wb_tag    = wb_tag_r;
    assign abort_mem = abort_r;
    assign proto_err = proto_r;

    // Snoop decision and FSM next state, all from the pre-edge table contents.
    always_comb begin
        upd_s        = 1'b0;
        new_st_s     = st_r[bus_index];
        wb_start_s   = 1'b0;
        abort_s      = 1'b0;
        proto_s      = 1'b0;
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && hit_s) begin
                    case (st_r[bus_index])
                        ST_SHR: begin
                            if (bus_msg != MSG_RM) begin
                                upd_s    = 1'b1;
                                new_st_s = ST_INV;
                            end else begin
                                upd_s    = 1'b0;
                            end
                        end
                        ST_EXC: begin
                            case (bus_msg)
                                MSG_RM: begin
                                    upd_s      = 1'b1;
                                    new_st_s   = ST_SHR;
                                    wb_start_s = 1'b1;
                                    abort_s    = 1'b1;
                                end
                                MSG_WM: begin
                                    upd_s      = 1'b1;
                                    new_st_s   = ST_INV;
                                    wb_start_s = 1'b1;
                                    abort_s    = 1'b1;
                                end
                                MSG_INV: begin
                                    upd_s    = 1'b1;
                                    new_st_s = ST_INV;
                                    proto_s  = 1'b1;
                                end
                                default: begin
                                    upd_s = 1'b0;
                                end
                            endcase
                        end
                        default: begin
                            upd_s = 1'b0;
                        end
                    endcase
                end else begin
                    upd_s = 1'b0;
                end
                if (wb_start_s) begin
                    state_next_s = WB_WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WB_WAIT: begin
                if (wb_ack) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WB_WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Line table: snoop update first, a local write to the same line wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                st_r[i]  <= ST_INV;
                tag_r[i] <= {TAG_W{1'b0}};
            end
        end else begin
            if (upd_s) begin
                st_r[bus_index] <= new_st_s;
            end
            if (loc_we) begin
                st_r[loc_index]  <= loc_st_s;
                tag_r[loc_index] <= loc_tag;
            end
        end
    end

    // Registered write-back handshake and one-cycle abort/error pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_req_r   <= 1'b0;
            wb_index_r <= {IDX_W{1'b0}};
            wb_tag_r   <= {TAG_W{1'b0}};
            abort_r    <= 1'b0;
            proto_r    <= 1'b0;
        end else begin
            abort_r <= abort_s;
            proto_r <= proto_s;
            if (wb_start_s) begin
                wb_req_r   <= 1'b1;
                wb_index_r <= bus_index;
                wb_tag_r   <= tag_r[bus_index];
            end else if ((state_r == WB_WAIT) && wb_ack) begin
                wb_req_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_snoop_receptor.sv
// Self-checking bench for snoop_receptor: a behavioural table model predicts
// the registered outputs of every driven cycle into a scoreboard queue, and
// each scenario task pops and compares them after the clock edge.
module tb_snoop_receptor;

    localparam int NL = 4;
    localparam int TW = 4;
    localparam int IW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          bus_valid;
    logic [2:0]    bus_msg;
    logic [IW-1:0] bus_index;
    logic [TW-1:0] bus_tag;
    logic          bus_ready;
    logic          loc_we;
    logic [IW-1:0] loc_index;
    logic [TW-1:0] loc_tag;
    logic [1:0]    loc_state;
    logic [IW-1:0] rd_index;
    logic [1:0]    rd_state;
    logic [TW-1:0] rd_tag;
    logic          wb_req;
    logic [IW-1:0] wb_index;
    logic [TW-1:0] wb_tag;
    logic          wb_ack;
    logic          abort_mem;
    logic          proto_err;

    snoop_receptor #(.NUM_LINES(NL), .TAG_W(TW), .IDX_W(IW)) dut (
        .clock(clock), .reset(reset),
        .bus_valid(bus_valid), .bus_msg(bus_msg), .bus_index(bus_index),
        .bus_tag(bus_tag), .bus_ready(bus_ready),
        .loc_we(loc_we), .loc_index(loc_index), .loc_tag(loc_tag), .loc_state(loc_state),
        .rd_index(rd_index), .rd_state(rd_state), .rd_tag(rd_tag),
        .wb_req(wb_req), .wb_index(wb_index), .wb_tag(wb_tag), .wb_ack(wb_ack),
        .abort_mem(abort_mem), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    int nchk = 0;
    int nerr = 0;

    // Reference model of the table and handshake.
    logic [1:0]    m_st  [NL];
    logic [TW-1:0] m_tag [NL];
    logic          m_busy, m_wreq, m_abort, m_proto;
    logic [IW-1:0] m_widx;
    logic [TW-1:0] m_wtag;

    // Expected {wb_req, abort_mem, proto_err, bus_ready, wb_index, wb_tag}.
    logic [9:0] sb[$];
    logic [9:0] e;

    function automatic logic [9:0] obs();
        return {wb_req, abort_mem, proto_err, bus_ready, wb_index, wb_tag};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NL; i++) begin
            m_st[i]  = 2'd0;
            m_tag[i] = 4'd0;
        end
        m_busy  = 1'b0;
        m_wreq  = 1'b0;
        m_abort = 1'b0;
        m_proto = 1'b0;
        m_widx  = 2'd0;
        m_wtag  = 4'd0;
    endtask

    // Drive one clock of stimulus, predict the result and optionally queue it.
    task automatic drive(input bit push, input bit ack, input bit bv, input logic [2:0] msg,
                         input logic [1:0] idx, input logic [3:0] tag, input bit lwe,
                         input logic [1:0] lidx, input logic [3:0] ltag, input logic [1:0] lst);
        bit acc;
        bit hit;
        wb_ack    = ack;
        bus_valid = bv;
        bus_msg   = msg;
        bus_index = idx;
        bus_tag   = tag;
        loc_we    = lwe;
        loc_index = lidx;
        loc_tag   = ltag;
        loc_state = lst;
        acc = bv && !m_busy && (msg == 3'd1 || msg == 3'd2 || msg == 3'd3);
        hit = acc && (m_st[idx] != 2'd0) && (m_tag[idx] == tag);
        m_abort = 1'b0;
        m_proto = 1'b0;
        if (m_busy && ack) begin
            m_busy = 1'b0;
            m_wreq = 1'b0;
        end
        if (hit) begin
            if (m_st[idx] == 2'd2) begin
                if (msg == 3'd3) begin
                    m_proto   = 1'b1;
                    m_st[idx] = 2'd0;
                end else begin
                    m_abort   = 1'b1;
                    m_wreq    = 1'b1;
                    m_busy    = 1'b1;
                    m_widx    = idx;
                    m_wtag    = tag;
                    m_st[idx] = (msg == 3'd2) ? 2'd1 : 2'd0;
                end
            end else if (msg != 3'd2) begin
                m_st[idx] = 2'd0;
            end
        end
        if (lwe) begin
            m_st[lidx]  = (lst == 2'd3) ? 2'd0 : lst;
            m_tag[lidx] = ltag;
        end
        if (push) sb.push_back({m_wreq, m_abort, m_proto, !m_busy, m_widx, m_wtag});
        @(posedge clock);
        @(negedge clock);
        wb_ack    = 1'b0;
        bus_valid = 1'b0;
        loc_we    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        m_reset();
        nchk++;
        if (obs() !== 10'd0) begin nerr++; $display("FAIL reset_outputs act=%h exp=%h", obs(), 10'd0); end
        for (int i = 0; i < NL; i++) begin
            rd_index = i[1:0];
            #1;
            nchk++;
            if ({rd_state, rd_tag} !== 6'd0) begin nerr++; $display("FAIL reset_line%0d act=%h exp=0", i, {rd_state, rd_tag}); end
        end
        reset = 1'b0;
        #1;
        nchk++;
        if (bus_ready !== 1'b1) begin nerr++; $display("FAIL reset_release_ready act=%b exp=1", bus_ready); end
    endtask

    task automatic test_exclusive_read();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 1'b1, 2'd1, 4'd5, 2'd2);
        e = sb.pop_front(); nchk++;
        if (obs() !== e) begin nerr++; $display("FAIL exrd_locwr act=%h exp=%h", obs(), e); end
        drive(1'b1, 1'b0, 1'b1, 3'd2, 2'd1, 4'd5, 1'b0, 2'd0, 4'd0, 2'd0);
        e = sb.pop_front(); nchk++;
        if (obs() !== e || obs() !== {1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'd5}) begin nerr++; $display("FAIL exrd_accept act=%h exp=%h", obs(), e); end
        rd_index = 2'd1; #1; nchk++;
        if ({rd_state, rd_tag} !== {2'd1, 4'd5}) begin nerr++; $display("FAIL exrd_line1 act=%h exp=%h", {rd_state, rd_tag}, {2'd1, 4'd5}); end
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, (c == 2) ? 1'b1 : 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 2'd0);
            e = sb.pop_front(); nchk++;
            if (obs() !== e) begin nerr++; $display("FAIL exrd_wait%0d act=%h exp=%h", c, obs(), e); end
        end
    endtask

    task automatic test_shared();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 1'b1, 2'd2, 4'd3, 2'd1);
        drive(1'b1, 1'b0, 1'b1, 3'd2, 2'd2, 4'd3, 1'b0, 2'd0, 4'd0, 2'd0);
        e = sb.pop_front(); nchk++;
        if (obs() !== e) begin nerr++; $display("FAIL shr_rm act=%h exp=%h", obs(), e); end
        rd_index = 2'd2; #1; nchk++;
        if ({rd_state, rd_tag} !== {m_st[2], m_tag[2]}) begin nerr++; $display("FAIL shr_rm_line act=%h exp=%h", {rd_state, rd_tag}, {m_st[2], m_tag[2]}); end
        drive(1'b1, 1'b0, 1'b1, 3'd1, 2'd2, 4'd3, 1'b0, 2'd0, 4'd0, 2'd0);
        e = sb.pop_front(); nchk++;
        if (obs() !== e) begin nerr++; $display("FAIL shr_wm act=%h exp=%h", obs(), e); end
        #1; nchk++;
        if (rd_state !== 2'd0) begin nerr++; $display("FAIL shr_wm_line act=%h exp=0", rd_state); end
    endtask

    task automatic test_tag_miss();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 1'b1, 2'd0, 4'd7, 2'd2);
        drive(1'b1, 1'b0, 1'b1, 3'd2, 2'd0, 4'd6, 1'b0, 2'd0, 4'd0, 2'd0);
        e = sb.pop_front(); nchk++;
        if (obs() !== e) begin nerr++; $display("FAIL miss_rm act=%h exp=%h", obs(), e); end
        rd_index = 2'd0; #1; nchk++;
        if (rd_state !== 2'd2) begin nerr++; $display("FAIL miss_line act=%h exp=2", rd_state); end
        drive(1'b1, 1'b0, 1'b1, 3'd1, 2'd0, 4'd7, 1'b0, 2'd0, 4'd0, 2'd0);
        e = sb.pop_front(); nchk++;
        if (obs() !== e) begin nerr++; $display("FAIL miss_wm_hit act=%h exp=%h", obs(), e); end
        #1; nchk++;
        if (rd_state !== 2'd0) begin nerr++; $display("FAIL miss_wm_line act=%h exp=0", rd_state); end
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 2'd0);
        e = sb.pop_front(); nchk++;
        if (obs() !== e) begin nerr++; $display("FAIL miss_ack act=%h exp=%h", obs(), e); end
    endtask

    task automatic test_proto_err();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 1'b1, 2'd3, 4'd10, 2'd2);
        drive(1'b1, 1'b0, 1'b1, 3'd3, 2'd3, 4'd10, 1'b0, 2'd0, 4'd0, 2'd0);
        e = sb.pop_front(); nchk++;
        if (obs() !== e || proto_err !== 1'b1) begin nerr++; $display("FAIL proto_pulse act=%h exp=%h", obs(), e); end
        drive(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 2'd0);
        e = sb.pop_front(); nchk++;
        if (obs() !== e) begin nerr++; $display("FAIL proto_one_cycle act=%h exp=%h", obs(), e); end
        rd_index = 2'd3; #1; nchk++;
        if (rd_state !== 2'd0) begin nerr++; $display("FAIL proto_line act=%h exp=0", rd_state); end
    endtask

    task automatic test_busy_hold();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 1'b1, 2'd2, 4'd4, 2'd1);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 1'b1, 2'd1, 4'd2, 2'd2);
        drive(1'b1, 1'b0, 1'b1, 3'd2, 2'd1, 4'd2, 1'b0, 2'd0, 4'd0, 2'd0);
        e = sb.pop_front(); nchk++;
        if (obs() !== e) begin nerr++; $display("FAIL busy_start act=%h exp=%h", obs(), e); end
        drive(1'b1, 1'b0, 1'b1, 3'd3, 2'd2, 4'd4, 1'b0, 2'd0, 4'd0, 2'd0);
        e = sb.pop_front(); nchk++;
        if (obs() !== e) begin nerr++; $display("FAIL busy_blocked act=%h exp=%h", obs(), e); end
        drive(1'b1, 1'b1, 1'b1, 3'd3, 2'd2, 4'd4, 1'b0, 2'd0, 4'd0, 2'd0);
        e = sb.pop_front(); nchk++;
        if (obs() !== e) begin nerr++; $display("FAIL busy_ack act=%h exp=%h", obs(), e); end
        rd_index = 2'd2; #1; nchk++;
        if (rd_state !== 2'd1) begin nerr++; $display("FAIL busy_not_consumed act=%h exp=1", rd_state); end
        drive(1'b1, 1'b0, 1'b1, 3'd3, 2'd2, 4'd4, 1'b0, 2'd0, 4'd0, 2'd0);
        e = sb.pop_front(); nchk++;
        if (obs() !== e) begin nerr++; $display("FAIL busy_accept act=%h exp=%h", obs(), e); end
        #1; nchk++;
        if (rd_state !== 2'd0) begin nerr++; $display("FAIL busy_accept_line act=%h exp=0", rd_state); end
    endtask

    task automatic test_unused_msgs();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 1'b1, 2'd0, 4'd12, 2'd2);
        for (int m = 0; m < 8; m++) begin
            if (m >= 1 && m <= 3) continue;
            drive(1'b1, 1'b0, 1'b1, m[2:0], 2'd0, 4'd12, 1'b0, 2'd0, 4'd0, 2'd0);
            e = sb.pop_front(); nchk++;
            if (obs() !== e) begin nerr++; $display("FAIL unused_msg%0d act=%h exp=%h", m, obs(), e); end
        end
        rd_index = 2'd0; #1; nchk++;
        if ({rd_state, rd_tag} !== {2'd2, 4'd12}) begin nerr++; $display("FAIL unused_line act=%h exp=%h", {rd_state, rd_tag}, {2'd2, 4'd12}); end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 1'b1, 2'd3, 4'd9, 2'd3);
        rd_index = 2'd3; #1; nchk++;
        if ({rd_state, rd_tag} !== {2'd0, 4'd9}) begin nerr++; $display("FAIL loc_state11 act=%h exp=%h", {rd_state, rd_tag}, {2'd0, 4'd9}); end
    endtask

    task automatic test_same_edge_and_reset();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 1'b1, 2'd1, 4'd6, 2'd2);
        drive(1'b1, 1'b0, 1'b1, 3'd1, 2'd1, 4'd6, 1'b1, 2'd1, 4'd9, 2'd1);
        e = sb.pop_front(); nchk++;
        if (obs() !== e || wb_tag !== 4'd6) begin nerr++; $display("FAIL same_edge_wb act=%h exp=%h", obs(), e); end
        rd_index = 2'd1; #1; nchk++;
        if ({rd_state, rd_tag} !== {2'd1, 4'd9}) begin nerr++; $display("FAIL same_edge_line act=%h exp=%h", {rd_state, rd_tag}, {2'd1, 4'd9}); end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        m_reset();
        nchk++;
        if (wb_req !== 1'b0) begin nerr++; $display("FAIL midreset_wbreq act=%b exp=0", wb_req); end
        for (int i = 0; i < NL; i++) begin
            rd_index = i[1:0];
            #1;
            nchk++;
            if (rd_state !== 2'd0) begin nerr++; $display("FAIL midreset_line%0d act=%h exp=0", i, rd_state); end
        end
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, 2'd0);
        e = sb.pop_front(); nchk++;
        if (obs() !== e) begin nerr++; $display("FAIL post_reset act=%h exp=%h", obs(), e); end
    endtask

    initial begin
        reset     = 1'b1;
        bus_valid = 1'b0;
        bus_msg   = 3'd0;
        bus_index = 2'd0;
        bus_tag   = 4'd0;
        loc_we    = 1'b0;
        loc_index = 2'd0;
        loc_tag   = 4'd0;
        loc_state = 2'd0;
        rd_index  = 2'd0;
        wb_ack    = 1'b0;
        m_reset();
        @(negedge clock);
        test_reset();
        test_exclusive_read();
        test_shared();
        test_tag_miss();
        test_proto_err();
        test_busy_hold();
        test_unused_msgs();
        test_same_edge_and_reset();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/snoop_receptor.md
Name: snoop_receptor

Overview:
Bus-side snoop controller for one cache in the MSI snooping system. Consumes bus messages (write miss / read miss / invalidate) driven by the emitter of another cache and keeps a per-line state/tag table. Updates that table, requests write-backs of EXCLUSIVE lines and aborts the memory access when this cache supplies the data. The table also receives local state updates from this cache's own emitter path, and exposes a read port for the processor-side lookup.

Parameters:
NUM_LINES, 4, number of cache lines tracked (power of two, minimum 2)
TAG_W, 4, tag width in bits
IDX_W, 2, index width; equals log2(NUM_LINES)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
bus_valid  input  1  a bus message is present
bus_msg  input  3  000 none, 001 WRITE_MISS, 010 READ_MISS, 011 INVALIDATE; others ignored
bus_index  input  IDX_W  line index of the bus message
bus_tag  input  TAG_W  tag of the bus message
bus_ready  output  1  receptor can accept a bus message this cycle
loc_we  input  1  local table write from the emitter side
loc_index  input  IDX_W  local write index
loc_tag  input  TAG_W  local write tag
loc_state  input  2  local write state: 00 INVALID, 01 SHARED, 10 EXCLUSIVE
rd_index  input  IDX_W  lookup index
rd_state  output  2  combinational state of line rd_index
rd_tag  output  TAG_W  combinational tag of line rd_index
wb_req  output  1  write-back request; held until acknowledged
wb_index  output  IDX_W  index of the line being written back
wb_tag  output  TAG_W  tag of the line being written back
wb_ack  input  1  memory accepted the write-back
abort_mem  output  1  one-cycle pulse: memory must abort its response to the current bus miss
proto_err  output  1  one-cycle pulse: INVALIDATE hit a line held EXCLUSIVE

Behaviour:
- Reset:
  - all lines INVALID, all tags 0
  - wb_req, wb_index, wb_tag, abort_mem and proto_err are 0
  - FSM goes to IDLE
  - bus_ready is 0 while reset is high and 1 in the first cycle after release.
- FSM states: IDLE and WB_WAIT.
  - bus_ready = 1 only in IDLE and not in reset.
- Accept condition: bus_valid & bus_ready & bus_msg in {001, 010, 011}. Messages not accepted are dropped; the bus holds them.
- Hit condition: table[bus_index].tag == bus_tag and state != INVALID. A miss or an INVALID line causes no state change and no output.
- Hit transitions (table updated on the accepting edge):
  - SHARED + READ_MISS: stays SHARED; no action.
  - SHARED + WRITE_MISS or INVALIDATE: becomes INVALID; no write-back.
  - EXCLUSIVE + READ_MISS: becomes SHARED; write-back; abort_mem.
  - EXCLUSIVE + WRITE_MISS: becomes INVALID; write-back; abort_mem.
  - EXCLUSIVE + INVALIDATE: becomes INVALID; no write-back; proto_err pulse.
- Write-back handshake:
  - On the accepting edge: wb_req goes to 1, wb_index and wb_tag latch the line, and the FSM goes to WB_WAIT. abort_mem pulses high in the following cycle, aligned with the first cycle of wb_req.
  - In WB_WAIT, wb_req, wb_index and wb_tag are held stable until wb_ack is sampled high.
  - On that edge wb_req clears and the FSM returns to IDLE, so bus_ready is 1 in the next cycle.
  - wb_ack outside WB_WAIT is ignored.
- Output latency: all outputs except rd_state and rd_tag are registered, one cycle after acceptance.
- Local write: when loc_we is high, table[loc_index] <= {loc_tag, loc_state} at the clock edge, in any FSM state. loc_state 11 is stored as INVALID.
- Simultaneous local write and accepted snoop to the same index:
  - The snoop's outputs (wb_req, abort_mem, proto_err) are computed from the pre-edge table contents.
  - The stored entry takes the local write values.
  - Different indices: both updates apply.
- Read port: rd_state and rd_tag reflect table contents after the last edge; no bypass of same-cycle writes.
- Reset mid-operation: reset in WB_WAIT drops wb_req immediately at that edge and discards the pending write-back.
- Unused encodings: bus_msg 000, 1xx and unaccepted messages cause no change.

Test Plan:
1. Reset, then loc_we index 1, tag 5, EXCLUSIVE; READ_MISS index 1, tag 5 -> next cycle wb_req=1, wb_index=1, wb_tag=5, abort_mem=1 for one cycle, bus_ready=0. Table line 1 = SHARED. wb_ack after 3 cycles -> wb_req=0 and bus_ready=1 next cycle.
2. Line 2 SHARED, tag 3: READ_MISS tag 3 -> no outputs, stays SHARED. Then WRITE_MISS tag 3 -> INVALID, no wb_req.
3. Line 0 EXCLUSIVE, tag 7: READ_MISS tag 6 (tag mismatch) -> no change. Then WRITE_MISS tag 7 -> INVALID, wb_req=1, abort_mem pulse.
4. Line 3 EXCLUSIVE: INVALIDATE with matching tag -> proto_err one-cycle pulse, line INVALID, wb_req=0.
5. While in WB_WAIT, assert bus_valid with INVALIDATE -> bus_ready=0 and the message is not consumed. It is accepted in the first IDLE cycle after wb_ack.
6. Same edge: accepted WRITE_MISS on EXCLUSIVE line 1 and loc_we to line 1 with SHARED, tag 9 -> wb_req=1 with the old tag; table line 1 = SHARED, tag 9. Reset asserted during WB_WAIT -> wb_req=0 and all lines INVALID next cycle.
